trng_sample_reader: RTL and testbench

//  Consumer end of the sampled-entropy path: drains NBITS-wide samples produced by the

---
 rtl/trng_sample_reader.sv | 154 +++++++++++++++
 tb/tb_trng_sample_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_sample_reader.sv
// rtl/trng_sample_reader.sv - packs entropy samples into words and buffers them in a drop-on-full FIFO
//
// Purpose: drains NBITS-wide entropy samples, packs SPW = WORD_W/NBITS of them into one
// WORD_W-bit word (first sample in the MSBs) and queues the word in a DEPTH-entry FIFO
// that is read over a valid/ready handshake. The source cannot be stalled, so a word
// completed while the FIFO is full is discarded and its samples are counted as lost.
//
// Ports:
//   clk, rst_ni    clock, synchronous active-low reset
//   sample_i       NBITS sample bits, qualified by sample_vld_i
//   clear_i        synchronous flush of packer, FIFO and loss counters
//   rd_data_o      FIFO head word, meaningful while rd_valid_o is high
//   rd_valid_o     head word valid; popped when rd_ready_i is also high
//   level_o        FIFO occupancy 0..DEPTH
//   overflow_o     sticky flag: at least one sample dropped
//   drop_cnt_o     dropped-sample count, saturating
module trng_sample_reader #(
    parameter int unsigned NBITS  = 1,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic [NBITS-1:0]           sample_i,
    input  logic                       sample_vld_i,
    input  logic                       clear_i,
    output logic [WORD_W-1:0]          rd_data_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned SPW = WORD_W / NBITS;
    localparam int unsigned CW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;

    if (WORD_W % NBITS != 0) begin : g_bad_word_w
        $error("trng_sample_reader: WORD_W must be a multiple of NBITS");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("trng_sample_reader: DEPTH must be a power of two >= 2");
    end

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // Accumulator after shifting in the current sample; on the completing sample this
    // is exactly the word that goes to the FIFO.
    logic [WORD_W-1:0] shifted;
    if (SPW == 1) begin : g_single
        assign shifted = sample_i;
    end else begin : g_shift
        assign shifted = {acc_q[WORD_W-NBITS-1:0], sample_i};
    end

    logic        pop;
    logic        last;
    logic        push;
    logic [16:0] drop_sum;

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        pop      = (level_q != '0) && rd_ready_i;
        last     = sample_vld_i && (cnt_q == CW'(SPW - 1));
        // A full FIFO still takes the word when the head leaves on the same edge.
        push     = last && ((level_q != LW'(DEPTH)) || pop);
        drop_sum = {1'b0, drop_cnt_q} + 17'(SPW);

        if (sample_vld_i) begin
            acc_d = shifted;
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = shifted;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (last && !push) begin
            overflow_d = 1'b1;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clear_i) begin
            acc_d      = '0;
            cnt_d      = '0;
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Memory is cleared on reset/flush so the head reads as zero when the FIFO is empty
    // after either event.
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (level_q != '0);
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_trng_sample_reader.sv
// tb/tb_trng_sample_reader.sv - scoreboard bench for trng_sample_reader (NBITS=1, WORD_W=8, DEPTH=2)
module tb_trng_sample_reader;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [0:0] sample_i = '0;
    logic       sample_vld_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       rd_ready_i = 1'b0;
    logic [1:0] level_o;
    logic       overflow_o;
    logic [15:0] drop_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    trng_sample_reader #(.NBITS(1), .WORD_W(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .clear_i      (clear_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: a list of pending bits, a count of words in the buffer, and a
    // scoreboard of accepted words in delivery order.
    int         m_bits[$];
    int         m_level = 0;
    bit         m_ovf = 0;
    int         m_drop = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst_ni || clear_i) begin
            m_bits.delete();
            m_level = 0;
            m_ovf   = 0;
            m_drop  = 0;
            exp_q.delete();
        end else begin
            bit         do_pop;
            bit         accept;
            int         word;
            do_pop = (m_level > 0) && rd_ready_i;
            accept = 0;
            if (sample_vld_i) begin
                m_bits.push_back(int'(sample_i));
                if (m_bits.size() == 8) begin
                    word = 0;
                    foreach (m_bits[i]) word = word * 2 + m_bits[i];
                    m_bits.delete();
                    if (m_level < DEPTH || do_pop) begin
                        accept = 1;
                        exp_q.push_back(8'(word));
                    end else begin
                        m_ovf  = 1;
                        m_drop = (m_drop + 8 > 65535) ? 65535 : m_drop + 8;
                    end
                end
            end
            m_level = m_level + int'(accept) - int'(do_pop);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if ($time > 0) begin
            check("valid", rd_valid_o, exp_q.size() != 0);
            check("level", level_o, m_level);
            check("overflow", overflow_o, m_ovf);
            check("drop_cnt", drop_cnt_o, m_drop);
            if (rd_valid_o && exp_q.size() != 0) begin
                check("rd_data", rd_data_o, exp_q[0]);
                if (rd_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after a posedge and are applied at the next posedge.
    task automatic cyc(input logic v, input logic b, input logic r,
                       input logic c = 1'b0, input logic rn = 1'b1);
        sample_vld_i = v;
        sample_i     = b;
        rd_ready_i   = r;
        clear_i      = c;
        rst_ni       = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bits(input logic [7:0] w, input int nbits, input logic r, input int gap);
        for (int i = 7; i > 7 - nbits; i--) begin
            cyc(1'b1, w[i], r);
            repeat (gap) cyc(1'b0, 1'b0, r);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_level", level_o, 0);
        check("reset_valid", rd_valid_o, 0);
        check("reset_data", rd_data_o, 0);

        // 1: back-to-back bits, word visible one cycle after the last bit
        feed_bits(8'hB2, 8, 1'b1, 0);
        check("t1_valid", rd_valid_o, 1);
        check("t1_data", rd_data_o, 8'hB2);
        cyc(1'b0, 1'b0, 1'b1);
        check("t1_level", level_o, 0);
        check("t1_single", rd_valid_o, 0);

        // 2: sparse sampling enable
        feed_bits(8'hB2, 8, 1'b1, 2);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // 3: overflow with stalled reader, then drain in order
        feed_bits(8'h01, 8, 1'b0, 0);
        feed_bits(8'h02, 8, 1'b0, 0);
        feed_bits(8'h03, 8, 1'b0, 0);
        check("t3_level", level_o, 2);
        check("t3_ovf", overflow_o, 1);
        check("t3_drop", drop_cnt_o, 8);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("t3_head", rd_data_o, 8'h01);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // 4: push into a full FIFO on the same edge as a pop
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        feed_bits(8'h11, 8, 1'b0, 0);
        feed_bits(8'h22, 8, 1'b0, 0);
        feed_bits(8'h33, 7, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b1);
        check("t4_level", level_o, 2);
        check("t4_ovf", overflow_o, 0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);

        // 5: clear mid-word with a full, overflowed FIFO
        feed_bits(8'h44, 8, 1'b0, 0);
        feed_bits(8'h55, 8, 1'b0, 0);
        feed_bits(8'h66, 8, 1'b0, 0);
        feed_bits(8'hF0, 5, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_level", level_o, 0);
        check("t5_valid", rd_valid_o, 0);
        check("t5_ovf", overflow_o, 0);
        check("t5_drop", drop_cnt_o, 0);
        feed_bits(8'h5A, 8, 1'b0, 0);
        check("t5_word", rd_data_o, 8'h5A);
        repeat (2) cyc(1'b0, 1'b0, 1'b1);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 299) == 0);

        // 6: reset mid-operation, then saturation of the drop counter
        feed_bits(8'hA5, 8, 1'b0, 0);
        feed_bits(8'h3C, 8, 1'b0, 0);
        feed_bits(8'h77, 8, 1'b0, 0);
        feed_bits(8'h0F, 3, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rst_data", rd_data_o, 0);
        check("t6_rst_valid", rd_valid_o, 0);
        check("t6_rst_level", level_o, 0);
        check("t6_rst_ovf", overflow_o, 0);
        check("t6_rst_drop", drop_cnt_o, 0);
        for (int i = 0; i < 8192 * 8 + 64; i++) cyc(1'b1, 1'($urandom), 1'b0);
        check("t6_sat", drop_cnt_o, 16'hFFFF);
        check("t6_sat_ovf", overflow_o, 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
